// File: rtl/emmc_pkg.sv
// emmc_pkg: shared FSM states and framing constants for the eMMC CMD line engine
package emmc_pkg;
  typedef enum logic [2:0] {IDLE, TX, TURN, WAIT, RX, DONE} state_t;
  localparam int FRAME_LEN = 48;
  localparam int TURN_LEN = 2;
  localparam logic [6:0] CRC7_POLY = 7'h09;
endpackage

// File: rtl/emmc_crc7.sv
// emmc_crc7: serial CRC7 (x^7+x^3+1), one data bit per enabled cycle
module emmc_crc7
  import emmc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_d,
  output logic [6:0] o_crc
);
  always_ff @(posedge clk)
    if (rst || i_clr) o_crc <= '0;
    else if (i_en) o_crc <= {o_crc[5:0], 1'b0} ^ ({7{i_d ^ o_crc[6]}} & CRC7_POLY);
endmodule

// File: rtl/emmc_cmd_line.sv
// emmc_cmd_line: eMMC CMD line engine, sends 48-bit commands and collects 48-bit responses
module emmc_cmd_line
  import emmc_pkg::*;
#(
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_expected,
  input  logic        resp_no_crc,
  output logic        resp_valid,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        resp_crc_err,
  output logic        resp_timeout,
  output logic        cmd_o,
  output logic        cmd_oe,
  input  logic        cmd_i
);
  localparam int CW = ($clog2(TIMEOUT_BITS) > 6) ? $clog2(TIMEOUT_BITS) : 6;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [47:0] r_sh;
  logic r_exp, r_nocrc;
  logic [6:0] w_crc;
  logic [46:0] w_rx;
  logic w_start, w_crc_en, w_crc_clr, w_crc_slot, w_crc_err;
  logic w_tx_last, w_turn_last, w_wait_last, w_rx_last;
  assign w_start = cmd_valid & cmd_ready;
  assign cmd_ready = (r_state == IDLE) & ~rst;
  assign resp_valid = r_state == DONE;
  assign w_rx = {r_sh[45:0], cmd_i};
  assign w_tx_last = r_cnt == CW'(FRAME_LEN);
  assign w_turn_last = r_cnt == CW'(TURN_LEN - 1);
  assign w_wait_last = r_cnt == CW'(TIMEOUT_BITS - 1);
  assign w_rx_last = r_cnt == CW'(FRAME_LEN - 1);
  assign w_crc_slot = r_cnt == CW'(FRAME_LEN - 8);
  // TX and RX share one CRC; r_cnt below 40 means the bit belongs to the covered span 47..8
  assign w_crc_clr = (r_state == IDLE) | (r_state == TURN);
  assign w_crc_en = bit_en & ((((r_state == TX) | (r_state == RX)) & (r_cnt < CW'(FRAME_LEN - 8)))
                              | ((r_state == WAIT) & ~cmd_i));
  assign w_crc_err = w_rx[46] | ~w_rx[0] | (~r_nocrc & (w_rx[7:1] != w_crc));
  emmc_crc7 u_crc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_d   ((r_state == TX) ? r_sh[47] : cmd_i),
    .o_crc (w_crc)
  );
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: w_state_n = w_start ? TX : IDLE;
      TX: if (bit_en && w_tx_last) w_state_n = r_exp ? TURN : DONE;
      TURN: if (bit_en && w_turn_last) w_state_n = WAIT;
      WAIT: if (bit_en) w_state_n = !cmd_i ? RX : w_wait_last ? DONE : WAIT;
      RX: if (bit_en && w_rx_last) w_state_n = DONE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sh <= '0;
      r_exp <= 1'b0;
      r_nocrc <= 1'b0;
      cmd_o <= 1'b1;
      cmd_oe <= 1'b0;
      resp_index <= '0;
      resp_arg <= '0;
      resp_crc_err <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_start) begin
        r_sh <= {2'b01, cmd_index, cmd_arg, 8'h00};
        r_exp <= resp_expected;
        r_nocrc <= resp_no_crc;
        r_cnt <= '0;
        cmd_oe <= 1'b1;
      end
      if (bit_en)
        case (r_state)
          TX:
            if (w_tx_last) begin
              cmd_oe <= 1'b0;
              cmd_o <= 1'b1;
              r_cnt <= '0;
              if (!r_exp) {resp_index, resp_arg, resp_crc_err, resp_timeout} <= '0;
            end else begin
              cmd_o <= w_crc_slot ? w_crc[6] : r_sh[47];
              r_sh <= w_crc_slot ? {w_crc[5:0], 1'b1, 41'd0} : {r_sh[46:0], 1'b0};
              r_cnt <= r_cnt + CW'(1);
            end
          TURN: r_cnt <= w_turn_last ? '0 : r_cnt + CW'(1);
          WAIT:
            if (!cmd_i) begin
              r_sh <= '0;
              r_cnt <= CW'(1);
            end else if (w_wait_last) begin
              r_cnt <= '0;
              {resp_index, resp_arg, resp_crc_err} <= '0;
              resp_timeout <= 1'b1;
            end else r_cnt <= r_cnt + CW'(1);
          RX: begin
            r_sh <= {r_sh[46:0], cmd_i};
            r_cnt <= r_cnt + CW'(1);
            if (w_rx_last) begin
              r_cnt <= '0;
              resp_index <= w_rx[45:40];
              resp_arg <= w_rx[39:8];
              resp_crc_err <= w_crc_err;
              resp_timeout <= 1'b0;
            end
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_emmc_cmd_line.sv
// tb_emmc_cmd_line: table-driven command/response vectors plus reset corner sequences
module tb_emmc_cmd_line;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst, bit_en, cmd_valid, cmd_ready, resp_expected, resp_no_crc;
  logic [5:0] cmd_index, resp_index;
  logic [31:0] cmd_arg, resp_arg;
  logic resp_valid, resp_crc_err, resp_timeout, cmd_o, cmd_oe, cmd_i;
  always #5 clk = ~clk;
  emmc_cmd_line #(.TIMEOUT_BITS(TO)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_expected(resp_expected),
    .resp_no_crc(resp_no_crc), .resp_valid(resp_valid), .resp_index(resp_index),
    .resp_arg(resp_arg), .resp_crc_err(resp_crc_err), .resp_timeout(resp_timeout),
    .cmd_o(cmd_o), .cmd_oe(cmd_oe), .cmd_i(cmd_i)
  );
  typedef struct {
    logic [5:0] idx; logic [31:0] arg; logic exp; logic nocrc; logic [47:0] frame;
    logic has_rep; logic [47:0] rep; int dly;
    logic [5:0] r_idx; logic [31:0] r_arg; logic err; logic to;
  } vec_t;
  vec_t v [11];
  int pass_n = 0, tot_n = 0, rv_cnt = 0, rv_tick = 0, ticks = 0;
  logic [5:0] cap_idx;
  logic [31:0] cap_arg;
  logic cap_err, cap_to;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic sample();
    if (resp_valid) begin
      rv_cnt++;
      rv_tick = ticks;
      cap_idx = resp_index;
      cap_arg = resp_arg;
      cap_err = resp_crc_err;
      cap_to = resp_timeout;
    end
  endtask
  task automatic tick();
    ticks++;
    @(negedge clk); bit_en = 1'b1;
    @(negedge clk); bit_en = 1'b0; sample();
    @(negedge clk); sample();
  endtask
  task automatic run_cmd(input int n, input vec_t c);
    logic [47:0] frame;
    int bits, tx_end, b;
    rv_cnt = 0;
    frame = '0;
    bits = 0;
    cmd_i = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d ready", n), cmd_ready, 1);
    cmd_index = c.idx; cmd_arg = c.arg; resp_expected = c.exp; resp_no_crc = c.nocrc;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_index = 6'h3F; cmd_arg = 32'hFFFF_FFFF;
    // cmd_valid stays high through TX to show it is ignored while busy
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!cmd_oe) break;
      frame = {frame[46:0], cmd_o};
      bits++;
    end
    cmd_valid = 1'b0;
    tx_end = ticks;
    check($sformatf("v%0d frame", n), frame, c.frame);
    check($sformatf("v%0d bits", n), bits, 48);
    if (c.exp)
      for (int t = 0; t < 300 && rv_cnt == 0; t++) begin
        b = 47 - (t - 2 - c.dly);
        cmd_i = (t < 2) ? 1'b0 : (c.has_rep && b >= 0 && b <= 47) ? c.rep[b] : 1'b1;
        tick();
      end
    cmd_i = 1'b1;
    tick();
    tick();
    check($sformatf("v%0d rv_pulses", n), rv_cnt, 1);
    check($sformatf("v%0d idx", n), cap_idx, c.r_idx);
    check($sformatf("v%0d arg", n), cap_arg, c.r_arg);
    check($sformatf("v%0d crc_err", n), cap_err, c.err);
    check($sformatf("v%0d timeout", n), cap_to, c.to);
    check($sformatf("v%0d held", n), {resp_index, resp_arg, resp_crc_err, resp_timeout},
          {c.r_idx, c.r_arg, c.err, c.to});
    if (c.to) check($sformatf("v%0d to_latency", n), rv_tick - tx_end, TO + 2);
  endtask
  initial begin
    v[0]  = '{6'd0,  32'h0,     1'b0, 1'b0, 48'h400000000095, 1'b0, 48'h0,            0,
              6'd0,  32'h0,        1'b0, 1'b0};
    v[1]  = '{6'd17, 32'h0,     1'b1, 1'b0, 48'h510000000055, 1'b1, 48'h110000090067, 5,
              6'd17, 32'h00000900, 1'b0, 1'b0};
    v[2]  = '{6'd17, 32'h0,     1'b1, 1'b0, 48'h510000000055, 1'b1, 48'h110000090065, 5,
              6'd17, 32'h00000900, 1'b1, 1'b0};
    v[3]  = '{6'd17, 32'h0,     1'b1, 1'b0, 48'h510000000055, 1'b0, 48'h0,            0,
              6'd0,  32'h0,        1'b0, 1'b1};
    v[4]  = '{6'd17, 32'h0,     1'b1, 1'b1, 48'h510000000055, 1'b1, 48'h3F80FF8000FF, 3,
              6'd63, 32'h80FF8000, 1'b0, 1'b0};
    v[5]  = '{6'd17, 32'h0,     1'b1, 1'b1, 48'h510000000055, 1'b1, 48'h3F80FF8000FE, 3,
              6'd63, 32'h80FF8000, 1'b1, 1'b0};
    v[6]  = '{6'd17, 32'h0,     1'b1, 1'b0, 48'h510000000055, 1'b1, 48'h110000090067, TO - 1,
              6'd17, 32'h00000900, 1'b0, 1'b0};
    v[7]  = '{6'd17, 32'h0,     1'b1, 1'b0, 48'h510000000055, 1'b1, 48'h110000090067, TO,
              6'd0,  32'h0,        1'b0, 1'b1};
    v[8]  = '{6'd8,  32'h1AA,   1'b0, 1'b0, 48'h48000001AA87, 1'b0, 48'h0,            0,
              6'd0,  32'h0,        1'b0, 1'b0};
    v[9]  = '{6'd55, 32'h0,     1'b1, 1'b0, 48'h770000000065, 1'b1, 48'h110000090067, 0,
              6'd17, 32'h00000900, 1'b0, 1'b0};
    v[10] = '{6'd17, 32'h0,     1'b1, 1'b0, 48'h510000000055, 1'b1, 48'h510000000055, 2,
              6'd17, 32'h0,        1'b1, 1'b0};
    rst = 1'b1; bit_en = 1'b0; cmd_valid = 1'b0; cmd_i = 1'b1;
    cmd_index = '0; cmd_arg = '0; resp_expected = 1'b0; resp_no_crc = 1'b0;
    repeat (3) @(negedge clk);
    check("rst ready", cmd_ready, 0);
    check("rst oe", cmd_oe, 0);
    check("rst cmd_o", cmd_o, 1);
    check("rst outputs", {resp_valid, resp_index, resp_arg, resp_crc_err, resp_timeout}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst ready", cmd_ready, 1);
    for (int i = 0; i < 11; i++) run_cmd(i, v[i]);
    // reset in the middle of a transmitted frame, with bit_en asserted alongside
    @(negedge clk);
    cmd_index = 6'd17; cmd_arg = '0; resp_expected = 1'b1; resp_no_crc = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) tick();
    check("midtx oe", cmd_oe, 1);
    rv_cnt = 0;
    rst = 1'b1; bit_en = 1'b1;
    @(negedge clk);
    check("midtx rst oe", cmd_oe, 0);
    check("midtx rst cmd_o", cmd_o, 1);
    check("midtx rst ready", cmd_ready, 0);
    check("midtx rst rv", resp_valid, 0);
    bit_en = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("midtx ready after", cmd_ready, 1);
    repeat (3) tick();
    check("midtx no rv", rv_cnt, 0);
    check("midtx oe after", cmd_oe, 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/emmc_cmd_line.md
EMMC_CMD_LINE -- requirements
Module: emmc_cmd_line

Interface
REQ-001 SHALL have parameter TIMEOUT_BITS, default 64: number of bit ticks to wait for a response start bit before timing out.
REQ-002 SHALL have port clk, input, 1, the only clock; all logic is rising-edge clk.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port bit_en, input, 1, bit-time strobe; line shifts and samples occur only on cycles with bit_en=1.
REQ-005 SHALL have ports cmd_valid (in, 1) and cmd_ready (out, 1), the command handshake.
REQ-006 SHALL have ports cmd_index (in, 6), cmd_arg (in, 32), resp_expected (in, 1), resp_no_crc (in, 1), all sampled at handshake.
REQ-007 SHALL have ports resp_valid (out, 1), resp_index (out, 6), resp_arg (out, 32), resp_crc_err (out, 1) and resp_timeout (out, 1).
REQ-008 SHALL have ports cmd_o (out, 1), cmd_oe (out, 1) and cmd_i (in, 1), connecting to the CMD pad tri-state buffer's core_in, core_oe and core_out.

Function
REQ-009 SHALL use states IDLE, TX, TURN, WAIT, RX and DONE.
REQ-010 SHALL assert cmd_ready only in IDLE.
REQ-011 SHALL capture the fields on a cmd_valid & cmd_ready cycle and enter TX.
REQ-012 SHALL build the TX frame as 48 bits sent MSB first: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1.
REQ-013 SHALL compute CRC7 with polynomial x^7+x^3+1 and initial value 0 over frame bits 47..8.
REQ-014 SHALL hold cmd_oe=1 throughout TX and change cmd_o only on bit_en cycles, one bit per bit_en.
REQ-015 SHALL, after the end bit's bit_en, set cmd_oe=0 and go to DONE (resp_expected=0) or TURN (resp_expected=1).
REQ-016 SHALL spend exactly 2 bit_en ticks in TURN, ignoring cmd_i, then enter WAIT.
REQ-017 SHALL, in WAIT, count bit_en ticks and enter RX on the first bit_en where cmd_i=0; that tick is response bit 47.
REQ-018 SHALL time out when TIMEOUT_BITS ticks pass in WAIT with no start bit, then enter DONE with resp_timeout=1.
REQ-019 SHALL, in RX, shift cmd_i on each bit_en until 48 bits are captured, then enter DONE.
REQ-020 SHALL set resp_crc_err=1 if transmission bit 46≠0, end bit 0≠1, or the received CRC7≠CRC7 of bits 47..8.
REQ-021 SHALL skip the CRC check when resp_no_crc=1 (R3), while still checking bits 46 and 0.
REQ-022 SHALL set resp_index from bits 45..40 and resp_arg from bits 39..8.
REQ-023 SHALL, in DONE, pulse resp_valid for exactly one clk cycle, then return to IDLE.
REQ-024 SHALL pulse resp_valid for no-response commands too, with error flags 0.
REQ-025 SHALL keep resp_index, resp_arg and the flags stable until the next resp_valid.
REQ-026 SHALL make resp_crc_err and resp_timeout mutually exclusive.
REQ-027 SHALL advance no state and no counter while bit_en=0.
REQ-028 SHALL ignore cmd_valid in every state other than IDLE.

Reset
REQ-029 SHALL, on rst=1, force state=IDLE, cmd_oe=0, cmd_o=1, cmd_ready=0 during reset, resp_valid=0, all response outputs 0, and all counters 0.
REQ-030 SHALL make rst override bit_en and, mid-TX or mid-RX, release the line the next cycle with no resp_valid.

Structure
REQ-031 SHALL place the state enum, frame length (48), turnaround length (2) and CRC7 polynomial (7'h09) in shared package emmc_pkg.
REQ-032 SHALL implement CRC7 as sub-module emmc_crc7 (serial, with clear, enable and data-bit inputs), instantiated once for TX and reused for RX.

Verification
REQ-033 SHALL cover CMD0: index 0, arg 0, resp_expected=0 -> cmd_o serial frame 0x400000000095, cmd_oe high 48 ticks, then resp_valid with flags 0.
REQ-034 SHALL cover CMD17: index 17, arg 0 -> frame 0x510000000055; device replies 0x110000090067 after 5 ticks -> resp_index=17, resp_arg=0x00000900, resp_crc_err=0.
REQ-035 SHALL cover a corrupted CRC: the same reply with last byte 0x65 -> resp_crc_err=1.
REQ-036 SHALL cover a timeout: resp_expected=1 and cmd_i held 1 -> resp_timeout=1 exactly TIMEOUT_BITS ticks after TURN.
REQ-037 SHALL cover R3: resp_no_crc=1 and reply 0x3F80FF8000FF -> resp_arg=0x80FF8000, resp_crc_err=0.
REQ-038 SHALL cover reset mid-TX: rst at bit 20 -> cmd_oe=0 the next cycle, no resp_valid, and cmd_ready=1 once rst=0.
